// File: rtl/tipi_xfer_ctrl.sv
// tipi_xfer_ctrl: TIPI byte-channel sequencer between the TI bus and the RPi.
// Optional PUSH/PULL watchdog: define TIPI_TIMEOUT_EN.
module tipi_xfer_ctrl #(
   parameter int unsigned SYNC_STAGES    = 2,
   parameter logic [7:0]  RESET_CODE     = 8'hF1,
   parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] ti_a,
   input  logic [7:0]  ti_data,
   input  logic        ti_memen,
   input  logic        ti_we,
   input  logic        ti_reset,
   output logic [7:0]  out_data,
   output logic        out_valid,
   input  logic        out_ready,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [7:0]  rpi_rd,
   output logic [7:0]  rpi_rc,
   output logic        busy,
   output logic        timeout_err
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_PUSH = 2'd1;
   localparam logic [1:0] S_PULL = 2'd2;
   localparam logic [1:0] S_ACK  = 2'd3;

   localparam logic [15:0] A_TD = 16'h5fff;
   localparam logic [15:0] A_TC = 16'h5ffd;

   logic [SYNC_STAGES-1:0] we_sync;
   logic [SYNC_STAGES-1:0] memen_sync;
   logic [SYNC_STAGES-1:0] tirst_sync;
   logic                   we_last;
   logic [15:0]            a_q;
   logic [7:0]             d_q;

   logic we_s;
   logic memen_s;
   logic tirst_s;
   logic clr;
   logic wr_ev;
   logic wr_td;
   logic wr_tc;

   logic [1:0] state;
   logic [7:0] td;
   logic [7:0] tc;
   logic [7:0] cmd;
   logic       tc_new;
   logic       abort;
   logic       tmo_hit;

   // Synchronisers idle high so a released bus never looks like a strobe.
   always_ff @(posedge clk) begin
      if (rst) begin
         we_sync    <= '1;
         memen_sync <= '1;
         tirst_sync <= '1;
         we_last    <= 1'b1;
         a_q        <= '0;
         d_q        <= '0;
      end else begin
         we_sync    <= {we_sync[SYNC_STAGES-2:0], ti_we};
         memen_sync <= {memen_sync[SYNC_STAGES-2:0], ti_memen};
         tirst_sync <= {tirst_sync[SYNC_STAGES-2:0], ti_reset};
         we_last    <= we_s;
         a_q        <= ti_a;
         d_q        <= ti_data;
      end
   end

   assign we_s    = we_sync[SYNC_STAGES-1];
   assign memen_s = memen_sync[SYNC_STAGES-1];
   assign tirst_s = tirst_sync[SYNC_STAGES-1];
   assign clr     = rst | ~tirst_s;

   assign wr_ev = we_last & ~we_s & ~memen_s;
   assign wr_td = wr_ev & (a_q == A_TD);
   assign wr_tc = wr_ev & (a_q == A_TC);

   assign abort = tc_new & (tc == RESET_CODE);

`ifdef TIPI_TIMEOUT_EN
   logic [31:0] tmo_cnt;

   always_ff @(posedge clk) begin
      if (clr) begin
         tmo_cnt <= '0;
      end else if (state == S_PUSH || state == S_PULL) begin
         tmo_cnt <= tmo_cnt + 32'd1;
      end else begin
         tmo_cnt <= '0;
      end
   end

   assign tmo_hit = (tmo_cnt == TIMEOUT_CYCLES - 32'd1);
`else
   assign tmo_hit = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (clr) begin
         state       <= S_IDLE;
         td          <= '0;
         tc          <= '0;
         cmd         <= '0;
         tc_new      <= 1'b0;
         out_data    <= '0;
         out_valid   <= 1'b0;
         in_ready    <= 1'b0;
         rpi_rd      <= '0;
         rpi_rc      <= '0;
         busy        <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (tc_new) begin
                  tc_new <= 1'b0;
                  cmd    <= tc;
                  if (tc == RESET_CODE) begin
                     rpi_rc <= RESET_CODE;
                     rpi_rd <= '0;
                  end else if (tc != rpi_rc) begin
                     busy <= 1'b1;
                     if (!tc[0]) begin
                        out_data  <= td;
                        out_valid <= 1'b1;
                        state     <= S_PUSH;
                     end else begin
                        in_ready <= 1'b1;
                        state    <= S_PULL;
                     end
                  end
               end
            end
            S_PUSH, S_PULL: begin
               if (abort) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b0;
                  tc_new    <= 1'b0;
                  rpi_rc    <= RESET_CODE;
                  rpi_rd    <= '0;
                  busy      <= 1'b0;
                  state     <= S_IDLE;
               end else if (out_valid && out_ready) begin
                  out_valid <= 1'b0;
                  state     <= S_ACK;
               end else if (in_ready && in_valid) begin
                  in_ready <= 1'b0;
                  rpi_rd   <= in_data;
                  state    <= S_ACK;
               end else if (tmo_hit) begin
                  out_valid   <= 1'b0;
                  in_ready    <= 1'b0;
                  timeout_err <= 1'b1;
                  busy        <= 1'b0;
                  state       <= S_IDLE;
               end
            end
            S_ACK: begin
               rpi_rc <= cmd;
               busy   <= 1'b0;
               state  <= S_IDLE;
            end
         endcase

         // A new write always wins over the FSM consuming the previous one.
         if (wr_td) begin
            td <= d_q;
         end
         if (wr_tc) begin
            tc          <= d_q;
            tc_new      <= 1'b1;
            timeout_err <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_tipi_xfer_ctrl.sv
// tb_tipi_xfer_ctrl: directed vector table plus hand-written multi-cycle
// sequences for tipi_xfer_ctrl (timeout sequence only with TIPI_TIMEOUT_EN).
module tb_tipi_xfer_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] ti_a;
   logic [7:0]  ti_data;
   logic        ti_memen;
   logic        ti_we;
   logic        ti_reset;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  rpi_rd;
   logic [7:0]  rpi_rc;
   logic        busy;
   logic        timeout_err;

   tipi_xfer_ctrl #(
      .SYNC_STAGES(2),
      .RESET_CODE(8'hF1),
      .TIMEOUT_CYCLES(64)
   ) dut (
      .clk(clk),
      .rst(rst),
      .ti_a(ti_a),
      .ti_data(ti_data),
      .ti_memen(ti_memen),
      .ti_we(ti_we),
      .ti_reset(ti_reset),
      .out_data(out_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .in_data(in_data),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .rpi_rd(rpi_rd),
      .rpi_rc(rpi_rc),
      .busy(busy),
      .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   int          n_vec = 0;
   int          n_err = 0;
   int          beats = 0;
   logic [7:0]  last_beat = 8'h00;

   always @(posedge clk) begin
      if (out_valid && out_ready) begin
         beats     = beats + 1;
         last_beat = out_data;
      end
   end

   typedef struct {
      logic [15:0] a;
      logic [7:0]  d;
      logic        ordy;
      logic        ival;
      logic [7:0]  idat;
      logic [7:0]  e_rc;
      logic [7:0]  e_rd;
      logic        e_busy;
      int          e_beats;
      logic [7:0]  e_last;
   } vec_t;

   localparam int NV = 12;
   vec_t tv [NV];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic ti_write(input logic [15:0] a, input logic [7:0] d);
      ti_a     = a;
      ti_data  = d;
      ti_memen = 1'b0;
      ti_we    = 1'b0;
      repeat (3) step();
      ti_we    = 1'b1;
      ti_memen = 1'b1;
      repeat (3) step();
   endtask

   initial begin
      tv[0]  = '{16'h5fff, 8'h5A, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 0, 8'h00};
      tv[1]  = '{16'h5ffd, 8'h02, 1'b1, 1'b0, 8'h00, 8'h02, 8'h00, 1'b0, 1, 8'h5A};
      tv[2]  = '{16'h5ffd, 8'h02, 1'b1, 1'b0, 8'h00, 8'h02, 8'h00, 1'b0, 1, 8'h5A};
      tv[3]  = '{16'h6000, 8'h77, 1'b1, 1'b0, 8'h00, 8'h02, 8'h00, 1'b0, 1, 8'h5A};
      tv[4]  = '{16'h5ffd, 8'h0A, 1'b1, 1'b0, 8'h00, 8'h0A, 8'h00, 1'b0, 2, 8'h5A};
      tv[5]  = '{16'h5fff, 8'hA5, 1'b1, 1'b0, 8'h00, 8'h0A, 8'h00, 1'b0, 2, 8'h5A};
      tv[6]  = '{16'h5ffd, 8'h08, 1'b1, 1'b0, 8'h00, 8'h08, 8'h00, 1'b0, 3, 8'hA5};
      tv[7]  = '{16'h5ffd, 8'h05, 1'b1, 1'b1, 8'h3C, 8'h05, 8'h3C, 1'b0, 3, 8'hA5};
      tv[8]  = '{16'h5ffd, 8'hF1, 1'b1, 1'b0, 8'h00, 8'hF1, 8'h00, 1'b0, 3, 8'hA5};
      tv[9]  = '{16'h5fff, 8'hE7, 1'b1, 1'b0, 8'h00, 8'hF1, 8'h00, 1'b0, 3, 8'hA5};
      tv[10] = '{16'h5ffd, 8'hF1, 1'b1, 1'b0, 8'h00, 8'hF1, 8'h00, 1'b0, 3, 8'hA5};
      tv[11] = '{16'h5ffd, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 4, 8'hE7};

      rst       = 1'b1;
      ti_a      = 16'h0000;
      ti_data   = 8'h00;
      ti_memen  = 1'b1;
      ti_we     = 1'b1;
      ti_reset  = 1'b1;
      out_ready = 1'b0;
      in_data   = 8'h00;
      in_valid  = 1'b0;
      repeat (3) step();
      rst = 1'b0;
      step();

      check("rst out_data", out_data, 8'h00);
      check("rst out_valid", out_valid, 1'b0);
      check("rst in_ready", in_ready, 1'b0);
      check("rst rpi_rd", rpi_rd, 8'h00);
      check("rst rpi_rc", rpi_rc, 8'h00);
      check("rst busy", busy, 1'b0);
      check("rst timeout_err", timeout_err, 1'b0);

      for (int i = 0; i < NV; i++) begin
         out_ready = tv[i].ordy;
         in_valid  = tv[i].ival;
         in_data   = tv[i].idat;
         ti_write(tv[i].a, tv[i].d);
         repeat (4) step();
         check($sformatf("v%0d rpi_rc", i), rpi_rc, tv[i].e_rc);
         check($sformatf("v%0d rpi_rd", i), rpi_rd, tv[i].e_rd);
         check($sformatf("v%0d busy", i), busy, tv[i].e_busy);
         check($sformatf("v%0d out_valid", i), out_valid, 1'b0);
         check($sformatf("v%0d in_ready", i), in_ready, 1'b0);
         check($sformatf("v%0d beats", i), beats, tv[i].e_beats);
         check($sformatf("v%0d last_beat", i), last_beat, tv[i].e_last);
      end

      // RPi->TI with in_valid arriving late
      out_ready = 1'b0;
      in_valid  = 1'b0;
      ti_write(16'h5ffd, 8'h03);
      check("pull busy", busy, 1'b1);
      check("pull in_ready", in_ready, 1'b1);
      check("pull rc hold", rpi_rc, 8'h00);
      repeat (8) step();
      in_valid = 1'b1;
      in_data  = 8'hC3;
      step();
      in_valid = 1'b0;
      check("pull rpi_rd", rpi_rd, 8'hC3);
      check("pull in_ready drop", in_ready, 1'b0);
      check("pull rc before ack", rpi_rc, 8'h00);
      step();
      check("pull rc ack", rpi_rc, 8'h03);
      check("pull busy done", busy, 1'b0);

      // Backpressure, td write during PUSH, then abort
      ti_write(16'h5fff, 8'h99);
      ti_write(16'h5ffd, 8'h04);
      check("bp out_valid", out_valid, 1'b1);
      check("bp out_data", out_data, 8'h99);
      check("bp busy", busy, 1'b1);
      repeat (100) step();
      ti_write(16'h5fff, 8'h11);
      check("bp out_data held", out_data, 8'h99);
      check("bp out_valid held", out_valid, 1'b1);
      check("bp no timeout", timeout_err, 1'b0);
      ti_write(16'h5ffd, 8'hF1);
      check("abort out_valid", out_valid, 1'b0);
      check("abort rpi_rc", rpi_rc, 8'hF1);
      check("abort rpi_rd", rpi_rd, 8'h00);
      check("abort busy", busy, 1'b0);
      out_ready = 1'b1;
      repeat (5) step();
      check("abort dropped", beats, 4);
      ti_write(16'h5ffd, 8'h02);
      repeat (4) step();
      check("post abort beats", beats, 5);
      check("post abort td", last_beat, 8'h11);
      check("post abort rc", rpi_rc, 8'h02);

      // TI reset held low for 3 cycles
      ti_reset = 1'b0;
      repeat (3) step();
      ti_reset = 1'b1;
      repeat (4) step();
      check("tirst rpi_rc", rpi_rc, 8'h00);
      check("tirst rpi_rd", rpi_rd, 8'h00);
      check("tirst busy", busy, 1'b0);
      check("tirst out_valid", out_valid, 1'b0);
      ti_write(16'h5ffd, 8'h02);
      repeat (4) step();
      check("tirst td cleared", last_beat, 8'h00);
      check("tirst beats", beats, 6);
      check("tirst rc", rpi_rc, 8'h02);

`ifdef TIPI_TIMEOUT_EN
      out_ready = 1'b0;
      ti_write(16'h5ffd, 8'h06);
      check("tmo busy early", busy, 1'b1);
      repeat (60) step();
      check("tmo busy late", busy, 1'b1);
      check("tmo err early", timeout_err, 1'b0);
      repeat (2) step();
      check("tmo busy off", busy, 1'b0);
      check("tmo out_valid", out_valid, 1'b0);
      check("tmo err set", timeout_err, 1'b1);
      check("tmo rc kept", rpi_rc, 8'h02);
      ti_write(16'h5ffd, 8'hF1);
      check("tmo err clear", timeout_err, 1'b0);
      check("tmo rc reset", rpi_rc, 8'hF1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
